// File: rtl/pic_pkg.sv
// Shared definitions for the interrupt controller: handshake states,
// default sizing and a lowest-set-bit helper used by the priority logic.
package pic_pkg;

  localparam int NUM_IR_DEF       = 8;
  localparam int SPURIOUS_LVL_DEF = 7;
  localparam int LVL_W            = 3;

  // CPU acknowledge handshake states.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    ACK1 = 3'd2,
    GAP  = 3'd3,
    ACK2 = 3'd4
  } state_e;

  // Index of the lowest set bit, with a flag telling whether any bit was set.
  typedef struct packed {
    logic             found;
    logic [LVL_W-1:0] idx;
  } lowest_t;

  // Scan from the top down so the last hit is the lowest index (highest priority).
  function automatic lowest_t lowest_set(input logic [NUM_IR_DEF-1:0] vec);
    lowest_t res;
    res.found = 1'b0;
    res.idx   = '0;
    for (int i = NUM_IR_DEF - 1; i >= 0; i--) begin
      if (vec[i]) begin
        res.found = 1'b1;
        res.idx   = LVL_W'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pic_priority_resolver.sv
// Fully nested priority resolution: the winner is the lowest-index eligible
// request that outranks the highest-priority level currently in service.
module pic_priority_resolver
  import pic_pkg::*;
#(
  parameter int NUM_IR = NUM_IR_DEF
) (
  input  logic [NUM_IR-1:0] eligible_i,
  input  logic [NUM_IR-1:0] isr_i,
  output logic [LVL_W-1:0]  winner_o,
  output logic              valid_o
);

  lowest_t           isr_low;
  lowest_t           win;
  logic [NUM_IR-1:0] nest_mask;

  // Restrict eligible requests to levels strictly above the in-service level.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path can hold a stale value (no latch).
    isr_low   = lowest_set(isr_i);
    nest_mask = '1;
    if (isr_low.found) begin
      nest_mask = (NUM_IR'(1) << isr_low.idx) - NUM_IR'(1);
    end
    win      = lowest_set(eligible_i & nest_mask);
    winner_o = win.idx;
    valid_o  = win.found;
  end

endmodule

// File: rtl/inta_sequencer.sv
// CPU-facing interrupt responder: raises INT, runs the two-pulse INTA
// handshake, owns the in-service register and handles EOI / AEOI.
module inta_sequencer
  import pic_pkg::*;
#(
  parameter int NUM_IR       = NUM_IR_DEF,
  parameter int SPURIOUS_LVL = SPURIOUS_LVL_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_IR-1:0] irr_in,
  input  logic [NUM_IR-1:0] imr,
  input  logic              inta_n,
  input  logic              eoi,
  input  logic              aeoi,
  input  logic [4:0]        vector_base,
  output logic              int_out,
  output logic [NUM_IR-1:0] irr_clear,
  output logic [NUM_IR-1:0] isr_out,
  output logic [7:0]        data_out,
  output logic              data_oe
);

  state_e            state_q, state_d;
  logic              inta_q;
  logic [LVL_W-1:0]  lvl_q, lvl_d;
  logic              spur_q, spur_d;
  logic [NUM_IR-1:0] isr_q, isr_d;
  logic [NUM_IR-1:0] irr_clear_q, irr_clear_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              data_oe_q, data_oe_d;

  logic [NUM_IR-1:0] eligible;
  logic [LVL_W-1:0]  winner;
  logic              valid;
  logic              inta_fall;
  logic              inta_rise;
  logic              isr_set;
  logic              aeoi_clr;
  lowest_t           eoi_low;

  assign eligible  = irr_in & ~imr;
  assign inta_fall = inta_q & ~inta_n;
  assign inta_rise = ~inta_q & inta_n;

  pic_priority_resolver #(
    .NUM_IR (NUM_IR)
  ) u_resolver (
    .eligible_i (eligible),
    .isr_i      (isr_q),
    .winner_o   (winner),
    .valid_o    (valid)
  );

  // Handshake sequencing: next state, frozen level, clear pulse and vector drive.
  always_comb begin
    state_d     = state_q;
    lvl_d       = lvl_q;
    spur_d      = spur_q;
    irr_clear_d = '0;
    data_out_d  = data_out_q;
    data_oe_d   = data_oe_q;
    isr_set     = 1'b0;
    aeoi_clr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (valid) state_d = REQ;
      end
      REQ: begin
        // The acknowledge wins over a request that vanishes in the same cycle;
        // that case becomes a spurious sequence.
        if (inta_fall) begin
          state_d = ACK1;
          if (valid) begin
            lvl_d       = winner;
            spur_d      = 1'b0;
            irr_clear_d = NUM_IR'(1) << winner;
            isr_set     = 1'b1;
          end else begin
            lvl_d  = LVL_W'(SPURIOUS_LVL);
            spur_d = 1'b1;
          end
        end else if (!valid) begin
          state_d = IDLE;
        end
      end
      ACK1: begin
        if (inta_rise) state_d = GAP;
      end
      GAP: begin
        if (inta_fall) begin
          state_d    = ACK2;
          data_out_d = {vector_base, lvl_q};
          data_oe_d  = 1'b1;
        end
      end
      ACK2: begin
        if (inta_rise) begin
          state_d    = IDLE;
          data_out_d = '0;
          data_oe_d  = 1'b0;
          aeoi_clr   = aeoi & ~spur_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ISR update: EOI acts on the pre-set value so a freshly acknowledged bit survives.
  always_comb begin
    eoi_low = lowest_set(isr_q);
    isr_d   = isr_q;
    if (eoi && eoi_low.found) isr_d[eoi_low.idx] = 1'b0;
    if (aeoi_clr)             isr_d[lvl_q]       = 1'b0;
    if (isr_set)              isr_d[winner]      = 1'b1;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= IDLE;
      inta_q      <= 1'b1;
      lvl_q       <= '0;
      spur_q      <= 1'b0;
      isr_q       <= '0;
      irr_clear_q <= '0;
      data_out_q  <= '0;
      data_oe_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      inta_q      <= inta_n;
      lvl_q       <= lvl_d;
      spur_q      <= spur_d;
      isr_q       <= isr_d;
      irr_clear_q <= irr_clear_d;
      data_out_q  <= data_out_d;
      data_oe_q   <= data_oe_d;
    end
  end

  assign int_out   = (state_q == REQ);
  assign irr_clear = irr_clear_q;
  assign isr_out   = isr_q;
  assign data_out  = data_out_q;
  assign data_oe   = data_oe_q;

endmodule

// File: tb/tb_inta_sequencer.sv
// Self-checking bench for inta_sequencer: directed scenarios followed by
// randomized handshakes, all checked against a transaction-level model.
module tb_inta_sequencer;

  logic       clk;
  logic       reset;
  logic [7:0] irr_in;
  logic [7:0] imr;
  logic       inta_n;
  logic       eoi;
  logic       aeoi;
  logic [4:0] vector_base;
  logic       int_out;
  logic [7:0] irr_clear;
  logic [7:0] isr_out;
  logic [7:0] data_out;
  logic       data_oe;

  int n_checks = 0;
  int n_errors = 0;

  // Model state: the in-service set as the bench believes it should be.
  logic [7:0] isr_m;

  inta_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .irr_in      (irr_in),
    .imr         (imr),
    .inta_n      (inta_n),
    .eoi         (eoi),
    .aeoi        (aeoi),
    .vector_base (vector_base),
    .int_out     (int_out),
    .irr_clear   (irr_clear),
    .isr_out     (isr_out),
    .data_out    (data_out),
    .data_oe     (data_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One full clock: inputs change and outputs are sampled on falling edges.
  task automatic step();
    @(negedge clk);
  endtask

  // Fully nested pick: lowest unmasked request ranked above every in-service level.
  function automatic void model_pick(input logic [7:0] req, input logic [7:0] msk,
                                     input logic [7:0] isr, output bit ok, output int lvl);
    int limit;
    limit = 8;
    for (int i = 7; i >= 0; i--) if (isr[i]) limit = i;
    ok  = 1'b0;
    lvl = 0;
    for (int i = 0; i < 8; i++) begin
      if (!ok && req[i] && !msk[i] && i < limit) begin
        ok  = 1'b1;
        lvl = i;
      end
    end
  endfunction

  function automatic logic [7:0] model_eoi(input logic [7:0] isr);
    logic [7:0] r;
    bit done;
    r = isr;
    done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!done && r[i]) begin
        r[i] = 1'b0;
        done = 1'b1;
      end
    end
    return r;
  endfunction

  task automatic pulse_eoi();
    eoi = 1'b1;
    step();
    eoi = 1'b0;
    isr_m = model_eoi(isr_m);
    check("isr_after_eoi", isr_out, isr_m);
  endtask

  // Present a request pattern and, if the model expects INT, run both INTA pulses.
  task automatic run_seq(input logic [7:0] irr_v, input logic [7:0] imr_v, input logic [4:0] vb,
                         input logic aeoi_v, input bit spur, input bit eoi_same, input bit scramble);
    bit         ok;
    int         lvl;
    logic [2:0] l3;
    logic [7:0] exp_clr;
    irr_in      = irr_v;
    imr         = imr_v;
    vector_base = vb;
    aeoi        = aeoi_v;
    model_pick(irr_v, imr_v, isr_m, ok, lvl);
    step();
    check("int_out_req", int_out, ok);
    if (ok) begin
      if (spur) begin
        irr_in = 8'h00;
        ok     = 1'b0;
        lvl    = 7;
      end
      inta_n = 1'b0;
      if (eoi_same) eoi = 1'b1;
      step();
      eoi = 1'b0;
      if (eoi_same) isr_m = model_eoi(isr_m);
      exp_clr = ok ? (8'h01 << lvl) : 8'h00;
      if (ok) isr_m[lvl] = 1'b1;
      check("irr_clear_pulse", irr_clear, exp_clr);
      check("isr_after_inta1", isr_out, isr_m);
      check("int_out_ack1", int_out, 1'b0);
      irr_in = irr_in & ~exp_clr;
      if (scramble) begin
        irr_in = 8'($urandom);
        imr    = 8'($urandom);
      end
      step();
      check("irr_clear_done", irr_clear, 8'h00);
      inta_n = 1'b1;
      step();
      check("oe_gap", data_oe, 1'b0);
      inta_n = 1'b0;
      step();
      l3 = lvl[2:0];
      check("data_oe_on", data_oe, 1'b1);
      check("vector", data_out, {vb, l3});
      step();
      check("vector_hold", data_out, {vb, l3});
      inta_n = 1'b1;
      step();
      if (aeoi_v && ok) isr_m[lvl] = 1'b0;
      check("data_oe_off", data_oe, 1'b0);
      check("data_out_off", data_out, 8'h00);
      check("isr_after_inta2", isr_out, isr_m);
    end
    irr_in = 8'h00;
    imr    = 8'h00;
    aeoi   = 1'b0;
    step();
    check("int_out_idle", int_out, 1'b0);
  endtask

  initial begin
    reset       = 1'b1;
    irr_in      = 8'h00;
    imr         = 8'h00;
    inta_n      = 1'b1;
    eoi         = 1'b0;
    aeoi        = 1'b0;
    vector_base = 5'b00001;
    isr_m       = 8'h00;
    repeat (2) step();
    reset = 1'b0;
    step();
    check("rst_int_out", int_out, 1'b0);
    check("rst_irr_clear", irr_clear, 8'h00);
    check("rst_isr", isr_out, 8'h00);
    check("rst_data_out", data_out, 8'h00);
    check("rst_data_oe", data_oe, 1'b0);

    // Basic handshake on IR2, vector 0x0A.
    run_seq(8'h04, 8'h00, 5'b00001, 1'b0, 1'b0, 1'b0, 1'b0);
    pulse_eoi();

    // Priority with IR2 masked: IR3 wins.
    run_seq(8'h0C, 8'h04, 5'b10101, 1'b0, 1'b0, 1'b0, 1'b1);

    // Nesting: IR5 blocked by IR3 in service, IR1 preempts.
    run_seq(8'h20, 8'h00, 5'b00011, 1'b0, 1'b0, 1'b0, 1'b0);
    run_seq(8'h22, 8'h00, 5'b00011, 1'b0, 1'b0, 1'b0, 1'b0);
    check("isr_nested", isr_out, 8'h0A);
    pulse_eoi();

    // Spurious: request vanishes with the first acknowledge.
    run_seq(8'h01, 8'h00, 5'b11110, 1'b0, 1'b1, 1'b0, 1'b0);
    pulse_eoi();
    pulse_eoi();

    // AEOI on IR6.
    run_seq(8'h40, 8'h00, 5'b01000, 1'b1, 1'b0, 1'b0, 1'b0);

    // EOI in the same cycle as the first acknowledge of a higher level.
    run_seq(8'h08, 8'h00, 5'b00100, 1'b0, 1'b0, 1'b0, 1'b0);
    run_seq(8'h02, 8'h00, 5'b00100, 1'b0, 1'b0, 1'b1, 1'b0);
    check("isr_eoi_same", isr_out, 8'h02);
    pulse_eoi();

    // Reset while waiting in GAP abandons the sequence.
    irr_in = 8'h10;
    step();
    check("rst_test_int", int_out, 1'b1);
    inta_n = 1'b0;
    step();
    irr_in = 8'h00;
    inta_n = 1'b1;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    isr_m = 8'h00;
    check("midrst_int_out", int_out, 1'b0);
    check("midrst_isr", isr_out, 8'h00);
    check("midrst_oe", data_oe, 1'b0);
    check("midrst_data", data_out, 8'h00);
    inta_n = 1'b0;
    step();
    check("stray_inta_oe", data_oe, 1'b0);
    check("stray_inta_clr", irr_clear, 8'h00);
    step();
    inta_n = 1'b1;
    step();
    check("stray_inta_oe2", data_oe, 1'b0);
    check("stray_inta_isr", isr_out, 8'h00);

    // Randomized handshakes against the model.
    for (int k = 0; k < 80; k++) begin
      run_seq(8'($urandom), 8'($urandom & $urandom), 5'($urandom), $urandom_range(0, 3) == 0,
              $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 1);
      if ($urandom_range(0, 1) == 1) pulse_eoi();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/inta_sequencer.md
Name: inta_sequencer

Overview:
- CPU-facing responder for the interrupt controller. It consumes the pending requests latched by the request register and resolves their priority against the mask and the in-service state.
- It raises INT to the CPU, then runs the two-pulse 8086-style INTA handshake:
  - first INTA: freezes the winning level, sets its ISR bit, and pulses a clear back to the request register;
  - second INTA: drives the 8-bit vector on the data bus.
- It owns the in-service register (ISR) and handles non-specific EOI and automatic EOI (AEOI).

Parameters:
- NUM_IR, 8, number of interrupt levels (the vector encoding assumes 8)
- SPURIOUS_LVL, 7, level reported when no request is valid at the first INTA

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- irr_in  input  8  pending requests from the request register; bit 0 = IR0 (highest priority)
- imr  input  8  interrupt mask; 1 = level masked
- inta_n  input  1  CPU acknowledge, active low; synchronous to clk, sampled each cycle
- eoi  input  1  one-cycle pulse, non-specific end-of-interrupt
- aeoi  input  1  level; 1 = automatic EOI mode
- vector_base  input  5  ICW2 bits T7..T3
- int_out  output  1  interrupt request to CPU
- irr_clear  output  8  one-hot, one-cycle pulse clearing the acknowledged bit in the request register
- isr_out  output  8  in-service register
- data_out  output  8  vector byte
- data_oe  output  1  data_out valid / bus drive enable

Behaviour:
- Reset (synchronous) forces the following; a reset mid-handshake abandons the sequence with no vector driven and no ISR change:
  - state = IDLE;
  - int_out = 0, irr_clear = 0, isr_out = 0, data_out = 0, data_oe = 0;
  - the registered copy of inta_n = 1.
- Eligibility:
  - eligible = irr_in & ~imr;
  - winner = lowest-index eligible bit whose index is strictly less than the lowest-index set ISR bit (fully nested mode);
  - with ISR = 0, every eligible bit qualifies;
  - valid = a winner exists.
- INTA edges: falling edge = registered inta_n was 1 and current inta_n is 0; rising edge = the reverse.
- State machine:
  - IDLE: when valid, go to REQ; int_out = 1 from the next cycle (1-cycle latency from irr_in).
  - REQ: int_out held at 1.
    - If valid drops before an INTA falling edge: return to IDLE and deassert int_out.
    - On INTA falling edge: latch lvl = winner, or SPURIOUS_LVL if not valid. If valid, set ISR[lvl] and pulse irr_clear[lvl] for exactly 1 cycle; if spurious, set no ISR bit and pulse no clear. Go to ACK1.
  - ACK1: wait for INTA rising edge, then go to GAP. int_out drops to 0 on entry to ACK1.
  - GAP: on INTA falling edge, go to ACK2 and drive data_out = {vector_base, lvl[2:0]}, data_oe = 1.
  - ACK2: hold data_out and data_oe while inta_n = 0.
    - On INTA rising edge: data_oe = 0, data_out = 0.
    - If aeoi = 1 and the sequence was non-spurious, clear ISR[lvl] in that same cycle.
    - Go to IDLE.
- Priority is frozen from the first INTA falling edge; irr_in and imr changes after that point do not alter lvl.
- eoi pulse: clears the lowest-index set ISR bit; no effect if ISR = 0. Accepted in any state.
- Same-cycle EOI and first-INTA ISR set: EOI acts on the ISR value before the set. The new bit survives even if it is now the highest priority.
- Re-arm: in IDLE, a still-eligible higher-priority request re-asserts int_out immediately (nesting).
- An INTA falling edge seen in IDLE, or an INTA pulse when int_out = 0, is ignored.

Decomposition:
- Shared package `pic_pkg` holds:
  - state enum (IDLE, REQ, ACK1, GAP, ACK2);
  - NUM_IR and SPURIOUS_LVL defaults;
  - a function returning the lowest set bit index plus a found flag, reused by the request-register logic.
- One natural sub-module: `pic_priority_resolver`, combinational. It takes eligible and ISR and returns winner and valid.

Test Plan:
1. Basic two-INTA handshake: reset, vector_base = 5'b00001, irr_in = 8'h04, imr = 0, then two INTA pulses.
   - Required: int_out = 1 one cycle after irr_in.
   - First falling edge: irr_clear = 8'h04 for 1 cycle; isr_out = 8'h04.
   - Second pulse: data_out = 8'h0A, data_oe = 1 while inta_n is low, then 0.
2. Priority plus mask: irr_in = 8'h0C, imr = 8'h04.
   - Required: lvl = 3, isr_out = 8'h08, data_out = {vector_base, 3'd3}.
3. Nesting: with isr_out = 8'h08, raise irr_in = 8'h20.
   - Required: int_out stays 0.
   - Raise irr_in bit 1: int_out = 1; after handshake isr_out = 8'h0A.
   - Pulse eoi: isr_out = 8'h08.
4. Spurious: in REQ, drop irr_in to 0 in the same cycle as the first INTA falling edge.
   - Required: no irr_clear, isr_out unchanged, vector = {vector_base, 3'd7}.
5. AEOI: aeoi = 1, request IR6, complete the handshake.
   - Required: isr_out = 8'h40 between pulses, 8'h00 in the cycle after the second INTA rising edge.
6. Reset mid-op: assert reset in GAP.
   - Required: all outputs 0 next cycle, state IDLE, no vector driven on a subsequent INTA pulse.
